// File: rtl/gcd_pkg.sv
// Shared types and defaults for the sequential subtractive-Euclid GCD engine.
// State encoding is shared so the bench and any wrappers decode it identically.
package gcd_pkg;

   localparam int GCD_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_t;

   typedef logic [GCD_WIDTH_DEFAULT-1:0] gcd_word_t;

   typedef struct packed {
      gcd_word_t gcd;
      gcd_word_t iters;
   } gcd_result_t;

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// One subtractive Euclid step: the larger operand loses the smaller one.
// Purely combinational; when A==B both operands pass through unchanged.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] A_next,
   output logic [WIDTH-1:0] B_next,
   output logic             eq,
   output logic             a_gt_b
);

   always_comb begin
      eq     = (A == B);
      a_gt_b = (A > B);
      A_next = A;
      B_next = B;
      // The larger value is always the minuend, so neither path underflows.
      if (!eq) begin
         if (a_gt_b) begin
            A_next = A - B;
         end else begin
            B_next = B - A;
         end
      end
   end

endmodule : gcd_step

// File: rtl/gcd_seq_engine.sv
// Handshaked GCD engine: accept operands, subtract one step per cycle, present result and step count.
// Result is held until out_ready; in_ready is high only in IDLE, so nothing is accepted while busy.
module gcd_seq_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_output,
   output logic [WIDTH-1:0] iters
);

   gcd_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] iters_q, iters_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] a_next, b_next;
   logic             step_eq, step_a_gt_b;
   logic             accept;
   logic             trivial;

   gcd_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .A      (a_q),
      .B      (b_q),
      .A_next (a_next),
      .B_next (b_next),
      .eq     (step_eq),
      .a_gt_b (step_a_gt_b)
   );

   assign accept  = in_valid && (state_q == IDLE);
   assign trivial = Clr || (X == '0) || (Y == '0);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      count_d     = count_q;
      result_d    = result_q;
      iters_d     = iters_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = X;
               b_d     = Y;
               count_d = '0;
               // Clear or any zero operand short-circuits straight to a zero result.
               if (trivial) begin
                  result_d    = '0;
                  iters_d     = '0;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end

         CALC: begin
            if (step_eq) begin
               result_d    = a_q;
               iters_d     = count_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               a_d     = a_next;
               b_d     = b_next;
               count_d = count_q + WIDTH'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         count_q     <= '0;
         result_q    <= '0;
         iters_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         count_q     <= count_d;
         result_q    <= result_d;
         iters_q     <= iters_d;
         out_valid_q <= out_valid_d;
      end
   end

   // step_a_gt_b is folded into a_next/b_next; kept on the port for debug visibility.
   logic unused_ok;
   assign unused_ok = step_a_gt_b;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign gcd_output = result_q;
   assign iters      = iters_q;

endmodule : gcd_seq_engine
